// File: rtl/cpu_sel_pkg.sv
// Shared register-select types for the writeback select encode/decode paths.
// Also provides the 8-to-3 leaf encoder used to build wider priority encoders.
package cpu_sel_pkg;

  localparam int NUM_REGS  = 32;
  localparam int REG_IDX_W = 5;

  typedef logic [NUM_REGS-1:0]  reg_sel_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic {IDLE, EMIT} ser_state_e;

  // Index of the lowest set bit in an 8-bit slice; 0 when the slice is empty.
  function automatic logic [2:0] pe8_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/priority_encoder_32_5.sv
// Lowest-set-bit encoder, 32 inputs to a 5-bit index.
// Built as four 8-to-3 leaves plus a 4-way group select, mirroring the decoder tree.
module priority_encoder_32_5
  import cpu_sel_pkg::*;
(
  input  logic [31:0] in,
  output reg_idx_t    idx,
  output logic        any
);

  logic [3:0] grp_any;
  logic [2:0] grp_idx [4];

  for (genvar g = 0; g < 4; g++) begin : g_leaf
    assign grp_any[g] = |in[g*8 +: 8];
    assign grp_idx[g] = pe8_idx(in[g*8 +: 8]);
  end

  // Scan groups high to low so the lowest non-empty group wins.
  always_comb begin
    idx = '0;
    for (int g = 3; g >= 0; g--) begin
      if (grp_any[g]) idx = {2'(g), grp_idx[g]};
    end
  end

  assign any = |grp_any;

endmodule

// File: rtl/onehot_index_serializer.sv
// Drains a multi-hot register-select vector into 5-bit indices, lowest first.
//
// state | meaning
// IDLE  | ready for a new vector; zero vectors are consumed and dropped
// EMIT  | presenting lowest pending index; clears it on each accepted handshake
module onehot_index_serializer
  import cpu_sel_pkg::*;
#(
  parameter int N    = 32,
  parameter int IDXW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [N-1:0]    req_vec,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IDXW-1:0] out_idx,
  output logic            out_last,
  output logic            busy
);

  ser_state_e   state;
  logic [N-1:0] pending;
  logic [N-1:0] pending_clr;
  reg_idx_t     enc_idx;
  logic         enc_any;
  logic         emitting;

  priority_encoder_32_5 u_enc (
    .in  (pending),
    .idx (enc_idx),
    .any (enc_any)
  );

  // Subtracting one flips the lowest set bit and the zeros below it.
  assign pending_clr = pending & (pending - 1'b1);

  assign emitting  = (state == EMIT);
  assign req_ready = (state == IDLE);
  assign out_valid = emitting;
  assign busy      = emitting;
  assign out_idx   = (emitting && enc_any) ? IDXW'(enc_idx) : '0;
  assign out_last  = emitting && enc_any && (pending_clr == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && (req_vec != '0)) begin
            pending <= req_vec;
            state   <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            pending <= pending_clr;
            if (out_last) state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          pending <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_index_serializer.sv
// Directed bench for onehot_index_serializer with hand-computed expectations.
module tb_onehot_index_serializer;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_vec;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_idx;
  logic        out_last;
  logic        busy;

  int total;
  int bad;

  onehot_index_serializer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_vec   (req_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [4:0] idx,
                         input logic last, input logic rdy);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".busy"},      32'(busy),      32'(v));
    chk({tag, ".out_idx"},   32'(out_idx),   32'(idx));
    chk({tag, ".out_last"},  32'(out_last),  32'(last));
    chk({tag, ".req_ready"}, 32'(req_ready), 32'(rdy));
  endtask

  initial begin
    logic [4:0] exp_idx;
    logic       rdy_pat [5];
    logic [4:0] idx_pat [5];
    logic       lst_pat [5];

    total     = 0;
    bad       = 0;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_vec   = '0;
    out_ready = 1'b0;
    #1;
    chk_out("reset_async", 1'b0, 5'd0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk_out("reset", 1'b0, 5'd0, 1'b0, 1'b1);

    // Bits 0 and 31
    req_valid = 1'b1;
    req_vec   = 32'h8000_0001;
    out_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    req_vec   = 'x;
    chk_out("ends.first", 1'b1, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk_out("ends.second", 1'b1, 5'd31, 1'b1, 1'b0);
    @(negedge clk);
    chk_out("ends.idle", 1'b0, 5'd0, 1'b0, 1'b1);

    // X on req_vec with req_valid low must not start a drain
    @(negedge clk);
    chk_out("x_idle", 1'b0, 5'd0, 1'b0, 1'b1);

    // All ones: 32 consecutive indices, busy exactly 32 cycles
    req_valid = 1'b1;
    req_vec   = 32'hFFFF_FFFF;
    @(negedge clk);
    req_valid = 1'b0;
    req_vec   = '0;
    for (int i = 0; i < 32; i++) begin
      exp_idx = 5'(i);
      chk_out($sformatf("full.%0d", i), 1'b1, exp_idx, (i == 31), 1'b0);
      @(negedge clk);
    end
    chk_out("full.idle", 1'b0, 5'd0, 1'b0, 1'b1);

    // Backpressure on 0x410
    rdy_pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    idx_pat = '{5'd4, 5'd4, 5'd4, 5'd10, 5'd10};
    lst_pat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    req_valid = 1'b1;
    req_vec   = 32'h0000_0410;
    out_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      out_ready = rdy_pat[i];
      chk_out($sformatf("bp.%0d", i), 1'b1, idx_pat[i], lst_pat[i], 1'b0);
      @(negedge clk);
    end
    chk_out("bp.idle", 1'b0, 5'd0, 1'b0, 1'b1);

    // Zero vector is consumed and dropped
    out_ready = 1'b1;
    req_valid = 1'b1;
    req_vec   = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_out($sformatf("zero.%0d", i), 1'b0, 5'd0, 1'b0, 1'b1);
    end

    // New request held during a drain is taken only after IDLE
    req_vec = 32'h0000_00F0;
    @(negedge clk);
    req_vec = 32'h0000_0001;
    for (int i = 4; i < 8; i++) begin
      exp_idx = 5'(i);
      chk_out($sformatf("hold.%0d", i), 1'b1, exp_idx, (i == 7), 1'b0);
      @(negedge clk);
    end
    chk_out("hold.idle", 1'b0, 5'd0, 1'b0, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    req_vec   = '0;
    chk_out("hold.new", 1'b1, 5'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk_out("hold.done", 1'b0, 5'd0, 1'b0, 1'b1);

    // Asynchronous reset mid-drain of 0xF00
    req_valid = 1'b1;
    req_vec   = 32'h0000_0F00;
    @(negedge clk);
    req_valid = 1'b0;
    req_vec   = '0;
    chk_out("rst.idx8", 1'b1, 5'd8, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk_out("rst.async", 1'b0, 5'd0, 1'b0, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_out($sformatf("rst.after.%0d", i), 1'b0, 5'd0, 1'b0, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/onehot_index_serializer.md
Name: onehot_index_serializer

Overview:
- Converts a multi-hot 32-bit register-select vector into a stream of 5-bit register indices, lowest index first.
- It is the encode direction of the write-select decoder. It serves multi-destination writeback, where one vector marks several registers to be written.
- It sits between the writeback collector (upstream) and the register-file write port (downstream).
- Each index is presented with a valid/ready handshake.

Parameters:
- N, 32, width of the input select vector (power of two).
- IDXW, $clog2(N) = 5, width of the emitted index.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- req_valid  input  1  upstream vector valid
- req_ready  output  1  block can accept a vector
- req_vec  input  N  multi-hot select vector
- out_valid  output  1  out_idx is valid
- out_ready  input  1  downstream accepts the index
- out_idx  output  IDXW  index of the lowest pending bit
- out_last  output  1  out_idx is the final pending bit of the vector
- busy  output  1  a vector is being drained

Behaviour:
- One clock. Reset is asynchronous and active-low. Everything below is sampled on the rising edge of clk.
- State: IDLE, EMIT. Holds a pending register [N-1:0].
- Reset values (reset_n low, immediate): state=IDLE, pending=0, req_ready=1, out_valid=0, out_idx=0, out_last=0, busy=0.
- req_ready = (state==IDLE).
- out_valid = busy = (state==EMIT).
- IDLE:
  - On req_valid && req_ready with req_vec != 0: pending <= req_vec, go to EMIT.
  - With req_vec == 0: the vector is consumed and dropped, no output, stay in IDLE.
- EMIT:
  - out_idx is the priority-encoded lowest set bit of pending. It is combinational from the register and held stable while out_ready is low.
  - out_last = (pending has exactly one set bit).
  - On out_valid && out_ready: clear that bit in pending.
  - If the cleared bit was the last one, go to IDLE on the same edge. The next cycle has req_ready=1 and out_valid=0.
- Latency: first index is valid the cycle after the accepting edge.
- Throughput: one index per cycle with out_ready held high. A K-bit vector drains in K cycles, then 1 IDLE cycle before the next accept. There is no bypass.
- Backpressure: out_idx, out_last and pending do not change while out_valid && !out_ready.
- req_valid during EMIT is ignored. The upstream must hold its vector (req_ready=0).
- Bit 31 set emits idx 31. Bit 0 emits idx 0. No wrap or saturation; indices strictly ascend within one vector.
- In IDLE, out_idx and out_last are don't-care but driven to 0.
- reset_n asserted mid-drain: pending is discarded immediately and the block returns to reset values. No partial index is emitted after release.
- X on req_vec when req_valid=0 must not propagate into state.

Decomposition:
- Shared package cpu_sel_pkg:
  - localparams NUM_REGS=32 and REG_IDX_W=5.
  - typedef reg_sel_t logic [NUM_REGS-1:0].
  - typedef reg_idx_t logic [REG_IDX_W-1:0].
  - enum ser_state_e {IDLE, EMIT}.
- One sub-module: priority_encoder_32_5.
  - Purely combinational: in[31:0] to idx[4:0] (lowest set bit) plus any flag.
  - Built hierarchically from 8-to-3 priority encoders, mirroring the decoder's tree structure.
  - Exhaustively testable on its own.

Test Plan:
- Reset, then req_vec=32'h8000_0001 with out_ready=1:
  - req_ready drops the cycle after accept.
  - Emits idx 0 (out_last=0), then idx 31 (out_last=1).
  - req_ready=1 the following cycle.
- req_vec=32'hFFFF_FFFF with out_ready=1: idx 0..31 on 32 consecutive cycles, out_last only on idx 31, busy high exactly 32 cycles.
- req_vec=32'h0000_0410 with out_ready toggling 0,0,1,0,1:
  - idx 4 is held for 3 cycles, then idx 10 is held 1 cycle then accepted.
  - No index is skipped or repeated.
- req_vec=0 with req_valid=1: accepted (req_ready stays 1), out_valid never asserts, state stays IDLE.
- During drain of 32'h0000_00F0: present req_valid=1, req_vec=32'h1. It is ignored until IDLE. Then it is accepted and emits idx 0.
- Drain 32'h0000_0F00. Assert reset_n=0 asynchronously after idx 8 is accepted:
  - out_valid=0 and req_ready=1 take effect immediately, without waiting for a clock edge.
  - After release, no stale idx 9..11 appears.
